// File: rtl/siso_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : siso_frame_rx_if
// Description : Bundle of the serial line input and the parallel valid/ready
//               output side of the serial frame receiver.
//               slave  - receiver view (samples si/ready, drives the rest)
//               master - line driver / consumer view
//               Signals: si, ready (into receiver); data_out, valid,
//               frame_err, overrun (out of receiver).
// Revision    : 1.0 - initial release
// ============================================================================
interface siso_frame_rx_if #(
    parameter int WIDTH = 8
) ();
    logic             si;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             ready;
    logic             frame_err;
    logic             overrun;

    modport slave (
        input  si,
        input  ready,
        output data_out,
        output valid,
        output frame_err,
        output overrun
    );

    modport master (
        output si,
        output ready,
        input  data_out,
        input  valid,
        input  frame_err,
        input  overrun
    );
endinterface
`default_nettype wire

// File: rtl/siso_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : siso_frame_rx
// Description : Serial frame receiver. Detects a start bit (0) on si, shifts
//               in WIDTH data bits MSB-first, checks the stop bit (1) and
//               places good words in a holding register with a valid/ready
//               handshake. Bad stop bits pulse frame_err; a good word that
//               arrives while the holding register is full and not being
//               drained pulses overrun and is dropped.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - siso_frame_rx_if.slave (si, ready in;
//                       data_out, valid, frame_err, overrun out)
// Revision    : 1.0 - initial release
// ============================================================================
module siso_frame_rx #(
    parameter int WIDTH = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    siso_frame_rx_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_DATA      = 2'd1;
    localparam logic [1:0] c_STOP      = 2'd2;
    localparam logic [1:0] c_WAIT_IDLE = 2'd3;

    // Counter value present while the final data bit is being sampled.
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic w_good_stop;
    logic w_bad_stop;
    logic w_load;
    logic w_drain;

    assign w_good_stop = (r_state == c_STOP) &&  bus.si;
    assign w_bad_stop  = (r_state == c_STOP) && !bus.si;
    // A full register being drained on this edge can take the new word.
    assign w_load      = w_good_stop && (!r_valid || bus.ready);
    assign w_drain     = r_valid && bus.ready;

    // Frame sequencing and data shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!bus.si) begin
                        r_state <= c_DATA;
                        r_cnt   <= '0;
                    end
                end
                c_DATA: begin
                    r_sr  <= {r_sr[WIDTH-2:0], bus.si};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= c_STOP;
                    end
                end
                c_STOP: begin
                    // Good stop returns straight to IDLE so a start bit on
                    // the next edge is accepted without an idle gap.
                    r_state <= bus.si ? c_IDLE : c_WAIT_IDLE;
                end
                c_WAIT_IDLE: begin
                    // Zeros here belong to a broken frame or a stuck line and
                    // must not be mistaken for a start bit.
                    if (bus.si) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Holding register, handshake and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad_stop;
            r_overrun   <= w_good_stop && !w_load;
            if (w_load) begin
                r_data  <= r_sr;
                r_valid <= 1'b1;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.data_out  = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: doc/siso_frame_rx.md
# siso_frame_rx

Serial frame receiver that takes a one-bit-per-clock serial stream produced by the team's shift-register transmit path and reassembles it into parallel words. It detects a start bit, shifts in WIDTH data bits MSB-first, and checks a stop bit. Good words are held in an output register with a valid/ready handshake. It sits at the receiving end of the serial link, between the line input and the parallel consumer logic.

## Interface
- WIDTH, 8, data bits per frame (legal range 2..32)
- clk  input  1  system clock; all sampling on rising edge
- rst_n  input  1  asynchronous, active-low reset
- si  input  1  serial line; idle high; one bit per clk cycle
- data_out  output  WIDTH  last accepted word, MSB = first data bit received
- valid  output  1  data_out holds an unconsumed word
- ready  input  1  consumer accepts data_out when valid && ready at a rising edge
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  one-cycle pulse: good frame completed while holding register full and not being drained

## Operation
- Frame format on si: start bit (0), WIDTH data bits MSB-first, stop bit (1). Line idles at 1.
- States: IDLE, DATA, STOP, WAIT_IDLE.
- IDLE: si==0 sampled -> DATA, bit counter cleared. si==1 -> stay.
- DATA: each edge shifts si into the shift register LSB (sr <= {sr[WIDTH-2:0], si}) and increments the counter. After the WIDTH-th data bit -> STOP.
- STOP, si==1: frame is good -> IDLE. A start bit may arrive on the very next edge (back-to-back frames, no idle gap required).
- STOP, si==0: frame_err pulses, word discarded, -> WAIT_IDLE.
- WAIT_IDLE: stay until si==1 sampled, then -> IDLE. A 0 seen in WAIT_IDLE is never taken as a start bit.
- Holding register on a good stop:
  - If valid==0, or valid && ready on the same edge: data_out <= sr, valid <= 1.
  - Otherwise: old word kept, new word dropped, overrun pulses.
- Handshake:
  - valid && ready on an edge with no simultaneous load: valid <= 0. data_out holds its value.
  - ready is ignored while valid==0.
- Counter width: $clog2(WIDTH+1) bits. No wrap occurs within a frame. The counter is cleared on every entry to DATA.
- frame_err and overrun never both assert in the same cycle.

## Timing
- Reset (rst_n low, any time, asynchronous): state=IDLE, counter=0, shift register=0, data_out=0, valid=0, frame_err=0, overrun=0. Reset mid-frame abandons the frame. After rst_n rises, the first 0 sampled in IDLE is treated as a start bit.
- Edge numbering: start bit sampled at edge E0, data bits at E1..E_WIDTH, stop bit at E_(WIDTH+1).
- valid, data_out, frame_err and overrun all update at E_(WIDTH+1). Latency from start-bit edge to valid is WIDTH+1 edges.
- frame_err and overrun are high for exactly one cycle after E_(WIDTH+1).
- Minimum frame period is WIDTH+2 cycles. Sustained throughput requires the consumer to accept within WIDTH+2 cycles of valid rising.
- ready has no combinational path to any output. All outputs are registered.

## Test plan
- Reset then frame 0xA5 (WIDTH=8): si = 0,1,0,1,0,0,1,0,1,1 on E0..E9 with ready=0 -> after E9 valid=1, data_out=0xA5, no error pulses. Raise ready for one edge -> valid=0, data_out stays 0xA5.
- Back-to-back frames 0x3C then 0xC3, no idle gap, ready held 1 -> valid pulses after E9 (0x3C) and after E19 (0xC3). frame_err=0 and overrun=0 throughout.
- Bad stop bit: frame 0xFF with stop=0, then si held 0 for 5 cycles, then 1, then a valid frame 0x81 -> frame_err one-cycle pulse after E9. No start is detected during the 0 run. 0x81 is received correctly, and valid never asserts for 0xFF.
- Overrun: frame 0x11 with ready=0, then frame 0x22 with ready=0 -> overrun pulse at the second stop edge and data_out stays 0x11. Repeat with ready=1 exactly at the second stop edge -> no overrun, data_out=0x22, valid stays 1.
- Reset mid-frame: assert rst_n low after E4 of a frame, release, then send 0x5A -> all outputs 0 during reset. 0x5A is received with correct latency.
- Idle line: si=1 for 50 cycles after reset -> valid, frame_err and overrun stay 0, and state remains IDLE.
